// File: rtl/treeval_sweep.sv
// Evaluates a stored decision tree (MAX/MIN/EXP per node) into a root value and root-child action.
// Latency: done pulses n+1 cycles after the edge that samples start (1 clear + n-1 sweep + 1 final).
// Backpressure: none; start and config writes are ignored while busy.
module treeval_sweep #(
    parameter int N_MAX    = 64,
    parameter int W_ADDR   = 6,
    parameter int W_N_DATA = 10,
    parameter int W_C_DATA = 10,
    parameter int W_REWARD = 10,
    parameter int W_WEIGHT = 10,
    parameter int FRAC     = 7,
    parameter int W_ACTION = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_weight,
    input  logic                       mem_par,
    input  logic                       mem_rew,
    input  logic                       mem_act,
    input  logic [W_ADDR-1:0]          mem_addr,
    input  logic [W_N_DATA-1:0]        mem_data,
    input  logic                       conf_nodes,
    input  logic [W_C_DATA-1:0]        conf_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       exp_change,
    output logic signed [W_REWARD-1:0] exp,
    output logic [W_ACTION-1:0]        act,
    output logic                       cfg_err
);
    localparam int W_P = W_REWARD + W_WEIGHT + 1;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;
    localparam logic [1:0] ST_FINAL = 2'd3;
    localparam logic [1:0] SG_EXP   = 2'b00;
    localparam logic [1:0] SG_MIN   = 2'b01;
    localparam logic signed [W_P-1:0] LP_RMAX = W_P'(2 ** (W_REWARD - 1) - 1);
    localparam logic signed [W_P-1:0] LP_RMIN = ~LP_RMAX;
    localparam logic [W_ADDR:0] LP_NMAX = (W_ADDR + 1)'(N_MAX);

    // configuration storage (not reset)
    logic [W_ADDR-1:0]          r_parent [0:N_MAX-1];
    logic signed [W_REWARD-1:0] r_reward [0:N_MAX-1];
    logic [W_WEIGHT-1:0]        r_weight [0:N_MAX-1];
    logic [W_ACTION-1:0]        r_act_mem[0:N_MAX-1];
    logic [1:0]                 r_strat  [0:N_MAX-1];
    // evaluation scratch: accumulated value, winning child, best child value (EXP tracking)
    logic signed [W_REWARD-1:0] r_acc    [0:N_MAX-1];
    logic signed [W_REWARD-1:0] r_best   [0:N_MAX-1];
    logic [W_ADDR-1:0]          r_win    [0:N_MAX-1];

    logic [N_MAX-1:0]  r_has_child;
    logic [N_MAX-1:0]  r_init;
    logic [1:0]        r_state;
    logic [W_ADDR-1:0] r_i;
    logic [W_ADDR:0]   r_n;

    logic                       w_idle;
    logic                       w_addr_ok;
    logic                       w_par_legal;
    logic [W_ADDR:0]            w_conf_n;
    logic signed [W_REWARD-1:0] w_v;
    logic signed [W_P-1:0]      w_prod;
    logic signed [W_P-1:0]      w_shift;
    logic signed [W_REWARD-1:0] w_c;
    logic [W_ADDR-1:0]          w_p;
    logic signed [W_REWARD:0]   w_sum;
    logic signed [W_REWARD-1:0] w_sum_sat;
    logic signed [W_REWARD-1:0] w_root;

    function automatic logic signed [W_REWARD-1:0] f_sat(input logic signed [W_P-1:0] x);
        if (x > LP_RMAX)      f_sat = LP_RMAX[W_REWARD-1:0];
        else if (x < LP_RMIN) f_sat = LP_RMIN[W_REWARD-1:0];
        else                  f_sat = x[W_REWARD-1:0];
    endfunction

    assign busy        = (r_state != ST_IDLE);
    assign w_idle      = (r_state == ST_IDLE);
    assign w_addr_ok   = (int'(mem_addr) < N_MAX);
    assign w_par_legal = (mem_data[W_ADDR-1:0] < mem_addr);

    // node-count load with clamping to [1, N_MAX]
    always_comb begin
        w_conf_n = conf_data[W_ADDR:0];
        if (conf_data == '0)             w_conf_n = (W_ADDR + 1)'(1);
        else if (int'(conf_data) > N_MAX) w_conf_n = LP_NMAX;
    end

    // per-node fold datapath: weighted child value and the EXP running sum
    always_comb begin
        w_v       = r_has_child[r_i] ? r_acc[r_i] : r_reward[r_i];
        w_prod    = w_v * $signed({1'b0, r_weight[r_i]});
        w_shift   = w_prod >>> FRAC;
        w_c       = f_sat(w_shift);
        w_p       = r_parent[r_i];
        w_sum     = {r_acc[w_p][W_REWARD-1], r_acc[w_p]} + {w_c[W_REWARD-1], w_c};
        w_sum_sat = f_sat({{(W_P - W_REWARD - 1){w_sum[W_REWARD]}}, w_sum});
        w_root    = r_has_child[0] ? r_acc[0] : r_reward[0];
    end

    // configuration memory writes, one strobe per cycle by priority
    always_ff @(posedge clk) begin
        if (!rst && w_idle && w_addr_ok) begin
            if (mem_par) begin
                if (w_par_legal) r_parent[mem_addr] <= mem_data[W_ADDR-1:0];
            end else if (mem_rew) begin
                r_reward[mem_addr] <= mem_data[W_REWARD-1:0];
            end else if (mem_act) begin
                r_act_mem[mem_addr] <= mem_data[W_ACTION-1:0];
                r_strat[mem_addr]   <= mem_data[W_ACTION+1:W_ACTION];
            end else if (mem_weight) begin
                r_weight[mem_addr] <= mem_data[W_WEIGHT-1:0];
            end
        end
    end

    // fold child r_i into its parent; later (lower) indices win ties
    always_ff @(posedge clk) begin
        if (!rst && r_state == ST_SWEEP) begin
            if (!r_init[w_p]) begin
                r_acc[w_p]  <= w_c;
                r_best[w_p] <= w_c;
                r_win[w_p]  <= r_i;
            end else if (r_strat[w_p] == SG_EXP) begin
                r_acc[w_p] <= w_sum_sat;
                if (w_c >= r_best[w_p]) begin
                    r_best[w_p] <= w_c;
                    r_win[w_p]  <= r_i;
                end
            end else if (r_strat[w_p] == SG_MIN) begin
                if (w_c <= r_acc[w_p]) begin
                    r_acc[w_p] <= w_c;
                    r_win[w_p] <= r_i;
                end
            end else begin
                if (w_c >= r_acc[w_p]) begin
                    r_acc[w_p] <= w_c;
                    r_win[w_p] <= r_i;
                end
            end
        end
    end

    // control FSM, tree shape bits and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_i         <= '0;
            r_n         <= (W_ADDR + 1)'(1);
            r_has_child <= '0;
            r_init      <= '0;
            cfg_err     <= 1'b0;
            exp         <= '0;
            act         <= '0;
            done        <= 1'b0;
            exp_change  <= 1'b0;
        end else begin
            done       <= 1'b0;
            exp_change <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_addr_ok && mem_par) begin
                        if (w_par_legal) r_has_child[mem_data[W_ADDR-1:0]] <= 1'b1;
                        else             cfg_err <= 1'b1;
                    end
                    if (conf_nodes) r_n <= w_conf_n;
                    if (start) r_state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    r_init  <= '0;
                    r_i     <= W_ADDR'(r_n - (W_ADDR + 1)'(1));
                    r_state <= (r_n == (W_ADDR + 1)'(1)) ? ST_FINAL : ST_SWEEP;
                end
                ST_SWEEP: begin
                    r_init[w_p] <= 1'b1;
                    if (r_i == W_ADDR'(1)) r_state <= ST_FINAL;
                    else                   r_i <= r_i - W_ADDR'(1);
                end
                default: begin
                    exp        <= w_root;
                    act        <= r_has_child[0] ? r_act_mem[r_win[0]] : '0;
                    exp_change <= (w_root != exp);
                    done       <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_treeval_sweep.sv
// Directed bench for treeval_sweep: hand-computed tree values, latency and handshake checks.
// Latency: each evaluation is timed from the start-sampling edge to the done pulse.
// Backpressure: exercises ignored start/config writes during busy and reset mid-sweep.
module tb_treeval_sweep;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_weight = 1'b0, mem_par = 1'b0, mem_rew = 1'b0, mem_act = 1'b0;
    logic [5:0] mem_addr = '0;
    logic [9:0] mem_data = '0;
    logic       conf_nodes = 1'b0;
    logic [9:0] conf_data = '0;
    logic       start = 1'b0;
    logic       busy, done, exp_change, cfg_err;
    logic [9:0] exp_o;
    logic [2:0] act_o;

    int n_assert = 0;
    int n_fail   = 0;

    treeval_sweep dut (
        .clk(clk), .rst(rst),
        .mem_weight(mem_weight), .mem_par(mem_par), .mem_rew(mem_rew), .mem_act(mem_act),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .conf_nodes(conf_nodes), .conf_data(conf_data),
        .start(start), .busy(busy), .done(done), .exp_change(exp_change),
        .exp(exp_o), .act(act_o), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // kind: 0 parent, 1 reward, 2 act/strat, 3 weight
    task automatic wr(input int kind, input int addr, input int data);
        mem_addr = addr[5:0];
        mem_data = data[9:0];
        mem_par    = (kind == 0);
        mem_rew    = (kind == 1);
        mem_act    = (kind == 2);
        mem_weight = (kind == 3);
        tick();
        {mem_par, mem_rew, mem_act, mem_weight} = 4'b0;
    endtask

    task automatic conf(input int n);
        conf_nodes = 1'b1;
        conf_data  = n[9:0];
        tick();
        conf_nodes = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // seven-node tree; root_sa = {strat, act} for node 0
    task automatic cfg_tree(input int root_sa);
        conf(7);
        wr(0, 1, 0); wr(0, 2, 0); wr(0, 3, 0);
        wr(0, 4, 1); wr(0, 5, 1); wr(0, 6, 1);
        wr(1, 0, 0); wr(1, 1, 0); wr(1, 2, -10); wr(1, 3, 0);
        wr(1, 4, 100); wr(1, 5, -50); wr(1, 6, 10);
        wr(3, 1, 64); wr(3, 2, 64); wr(3, 3, 128);
        wr(3, 4, 64); wr(3, 5, 64); wr(3, 6, 128);
        wr(2, 0, root_sa); wr(2, 1, 1); wr(2, 2, 0); wr(2, 3, 0);
        wr(2, 4, 0); wr(2, 5, 0); wr(2, 6, 0);
    endtask

    // pulse start, then count edges until done (bounded)
    task automatic run(input string tag, input int lat);
        int cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy"}, 32'(busy), 1);
        cnt = 0;
        while (!done && cnt < 100) begin
            tick();
            cnt++;
        end
        chk({tag, " latency"}, cnt, lat);
    endtask

    initial begin
        logic seen_done;
        do_reset();
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset exp_change", 32'(exp_change), 0);
        chk("reset cfg_err", 32'(cfg_err), 0);
        chk("reset exp", $signed(exp_o), 0);
        chk("reset act", 32'(act_o), 0);

        // root MAX (10_000), node1 EXP
        cfg_tree(16);
        run("max", 8);
        chk("max exp", $signed(exp_o), 17);
        chk("max act", 32'(act_o), 1);
        chk("max exp_change", 32'(exp_change), 1);
        tick();
        chk("max done pulse", 32'(done), 0);
        chk("max busy after", 32'(busy), 0);

        // root MIN (01_000), act[2]=010
        wr(2, 0, 8);
        wr(2, 2, 2);
        run("min", 8);
        chk("min exp", $signed(exp_o), -5);
        chk("min act", 32'(act_o), 2);
        chk("min exp_change", 32'(exp_change), 1);
        tick();

        run("rerun", 8);
        chk("rerun exp", $signed(exp_o), -5);
        chk("rerun exp_change", 32'(exp_change), 0);
        tick();

        // EXP saturation: 500 + 500 clamps to 511; tie on best child -> node 1
        do_reset();
        conf(3);
        wr(0, 1, 0); wr(0, 2, 0);
        wr(1, 1, 500); wr(1, 2, 500);
        wr(3, 1, 128); wr(3, 2, 128);
        wr(2, 0, 0); wr(2, 1, 1); wr(2, 2, 2);
        run("sat", 4);
        chk("sat exp", $signed(exp_o), 511);
        chk("sat act tie", 32'(act_o), 1);
        chk("sat exp_change", 32'(exp_change), 1);
        tick();

        // single node; start and mem_rew during busy are ignored
        do_reset();
        conf(1);
        wr(1, 0, -7);
        start = 1'b1;
        tick();
        mem_rew = 1'b1; mem_addr = 6'd0; mem_data = 10'd5;
        tick();
        start = 1'b0; mem_rew = 1'b0;
        chk("n1 busy mid", 32'(busy), 1);
        chk("n1 done mid", 32'(done), 0);
        tick();
        chk("n1 done", 32'(done), 1);
        chk("n1 exp", $signed(exp_o), -7);
        chk("n1 act", 32'(act_o), 0);
        tick();
        chk("n1 no restart", 32'(busy), 0);
        run("n1 rerun", 2);
        chk("n1 rerun exp", $signed(exp_o), -7);
        chk("n1 rerun exp_change", 32'(exp_change), 0);
        tick();
        chk("cfg_err before", 32'(cfg_err), 0);
        wr(0, 3, 5);
        chk("cfg_err illegal parent", 32'(cfg_err), 1);

        // reset three cycles into a seven-node sweep
        do_reset();
        cfg_tree(16);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        chk("abort exp", $signed(exp_o), 0);
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen_done = seen_done | done;
        end
        chk("abort no done", 32'(seen_done), 0);
        cfg_tree(16);
        run("after abort", 8);
        chk("after abort exp", $signed(exp_o), 17);
        chk("after abort act", 32'(act_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/treeval_sweep.md
Name: treeval_sweep

Overview:
- Parametrised successor to the fixed-size tree evaluator.
- Stores a configurable game/decision tree: parent pointer, leaf reward, edge weight, node strategy and node action per node.
- Each internal node is evaluated under a per-node MAX, MIN or EXP (weighted-sum) strategy; the result is the root expected reward plus the action of the winning root child.
- Evaluation runs on an explicit start/busy/done handshake, not on reset, so the tree can be re-evaluated after partial reconfiguration.

Parameters:
- N_MAX, 64, maximum node count (storage depth).
- W_ADDR, 6, node address width, at least clog2(N_MAX).
- W_N_DATA, 10, width of mem_data.
- W_C_DATA, 10, width of conf_data.
- W_REWARD, 10, signed reward/value width.
- W_WEIGHT, 10, unsigned weight width.
- FRAC, 7, weight fractional bits; 2^FRAC is weight 1.0.
- W_ACTION, 3, action width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mem_weight  in  1  write weight[mem_addr] from mem_data[W_WEIGHT-1:0].
- mem_par  in  1  write parent[mem_addr] from mem_data[W_ADDR-1:0].
- mem_rew  in  1  write reward[mem_addr] from mem_data[W_REWARD-1:0].
- mem_act  in  1  write act[mem_addr] from mem_data[W_ACTION-1:0] and strat[mem_addr] from mem_data[W_ACTION+1:W_ACTION] (00 EXP, 01 MIN, 10 MAX, 11 treated as MAX).
- mem_addr  in  W_ADDR  node index.
- mem_data  in  W_N_DATA  write data.
- conf_nodes  in  1  load node count from conf_data.
- conf_data  in  W_C_DATA  node count.
- start  in  1  single-cycle evaluation request.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle pulse when exp/act update.
- exp_change  out  1  pulses with done when the new exp differs from the previous exp.
- exp  out  W_REWARD  signed root value.
- act  out  W_ACTION  action of the winning root child.
- cfg_err  out  1  sticky illegal-parent-write flag.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - busy, done, exp_change, cfg_err, exp and act all go to 0.
  - Node count goes to 1; all has_child bits clear.
  - weight, reward, act and strat storage are not cleared.
- Config writes:
  - Accepted only in IDLE; ignored while busy.
  - Ignored when mem_addr >= N_MAX.
  - Priority when several strobes are asserted: mem_par > mem_rew > mem_act > mem_weight.
- Parent writes:
  - Legal only when parent < addr and addr != 0.
  - A legal write sets has_child[parent].
  - An illegal write is dropped and sets cfg_err.
  - Re-parenting a node does not clear the old parent's has_child bit.
- conf_nodes: value 0 loads 1; a value above N_MAX loads N_MAX.
- FSM states: IDLE, CLEAR, SWEEP, FINAL.
  - IDLE: start moves to CLEAR; busy=1 from the next cycle. start while busy is ignored.
  - CLEAR (1 cycle): clears the per-node init bits, sets i = n-1. If n=1, goes to FINAL.
  - SWEEP (1 node per cycle, i descending to 1):
    - v = has_child[i] ? acc[i] : reward[i].
    - c = sat((v * weight[i]) >>> FRAC): signed times unsigned, arithmetic shift (floor), saturated to W_REWARD signed range.
    - p = parent[i].
    - If init[p]=0: acc[p] = c, win[p] = i, init[p] = 1.
    - Otherwise: EXP does acc[p] = sat(acc[p] + c); MAX replaces when c >= acc[p]; MIN replaces when c <= acc[p]. Ties go to the lowest index.
    - For EXP nodes, win[p] tracks the child with the largest c; ties go to the lowest index.
    - At i=1, goes to FINAL.
  - FINAL (1 cycle):
    - exp = has_child[0] ? acc[0] : reward[0].
    - act = has_child[0] ? act[win[0]] : 0.
    - exp_change = (new exp != old exp); done=1; busy=0; returns to IDLE.
- Ordering invariant: parent < child guarantees every child is folded before its parent.
- Latency: done asserts n+1 cycles after the edge that samples start; busy is high for those n+1 cycles.
- A new start is accepted in the cycle after done.
- Reset mid-operation aborts the evaluation: no done, exp stays 0.

Test Plan:
- Seven-node tree, n=7:
  - Parents: 1,2,3→0 and 4,5,6→1.
  - Rewards: 2=-10, 3=0, 4=100, 5=-50, 6=10.
  - Weights: 64, 64, 128, 64, 64, 128 for nodes 1–6.
  - Strategies: root MAX, node1 EXP; act[1]=001.
  - start → done 8 cycles later, exp=17, act=001, exp_change=1.
- Same tree, root strat set to MIN, act[2]=010 → exp=-5 (10'b1111111011), act=010, exp_change=1.
- Rerun with no changes → done, exp=-5, exp_change=0.
- Saturation: n=3, root EXP, leaves 1 and 2 with reward 500 and weight 128 → exp=511, done 4 cycles after start.
- n=1 with reward[0]=-7 → exp=-7, act=0, done 2 cycles after start. start and mem_rew asserted during busy are ignored. A mem_par write of addr 3, parent 5 sets cfg_err.
- rst asserted 3 cycles into a 7-node sweep → busy=0, no done, exp=0. A fresh start after reset (with re-configuration) yields exp=17.
